// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared state encoding, defaults and index-width helper for div_arbiter.
package div_arb_pkg;
   localparam int STATE_W = 3;
   localparam int DEFAULT_TIMEOUT = 64;
   typedef enum logic [STATE_W-1:0] {S_IDLE, S_SEN1, S_BUSY, S_RESP, S_GAP} state_t;
   function automatic int idx_w(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction
endpackage

// File: rtl/div_arb_rr.sv
// rr_arbiter: round-robin picker; search starts at the pointer, pointer moves past the winner on update.
module rr_arbiter import div_arb_pkg::*; #(
   parameter int M = 4,
   localparam int IW = idx_w(M)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [M-1:0]  i_req,
   input  logic          i_update,
   output logic [M-1:0]  o_gnt_oh,
   output logic [IW-1:0] o_gnt_idx,
   output logic          o_any
);
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_idx;
   logic [IW-1:0] w_j;
   logic          w_any;
   // Walk from the farthest candidate back to the pointer so the closest hit wins.
   always_comb begin
      w_idx = '0;
      w_any = 1'b0;
      w_j   = '0;
      for (int k = M - 1; k >= 0; k--) begin
         w_j = IW'((int'(r_ptr) + k) % M);
         if (i_req[w_j]) begin
            w_idx = w_j;
            w_any = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) r_ptr <= '0;
      else if (i_update) r_ptr <= (int'(w_idx) == M - 1) ? '0 : w_idx + 1'b1;
   end
   assign o_gnt_idx = w_idx;
   assign o_any     = w_any;
   assign o_gnt_oh  = M'(1) << w_idx;
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one divider among M requesters with a two-step start and a BUSY watchdog.
// Define DIV_ARB_ZERO_CHECK_EN to answer zero divisors directly without starting the divider.
module div_arbiter import div_arb_pkg::*; #(
   parameter int N = 20,
   parameter int M = 4,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   localparam int IW = idx_w(M),
   localparam int CW = $clog2(TIMEOUT + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [M-1:0]    req,
   input  logic [M*N-1:0]  req_dividend,
   input  logic [M*N-1:0]  req_divisor,
   output logic [M-1:0]    rsp_valid,
   output logic [N-1:0]    rsp_q,
   output logic            rsp_err,
   output logic            busy,
   output logic [IW-1:0]   gnt_idx,
   output logic [N-1:0]    div_dividend,
   output logic [N-1:0]    div_divisor,
   output logic            div_sen1,
   output logic            div_sen2,
   input  logic [N-1:0]    div_q,
   input  logic            div_done
);
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_gnt;
   logic [M-1:0]  r_gnt_oh;
   logic [M-1:0]  r_rsp_valid;
   logic [N-1:0]  r_rsp_q;
   logic [N-1:0]  r_dividend;
   logic [N-1:0]  r_divisor;
   logic          r_rsp_err;
   logic          r_sen1;
   logic          r_sen2;
   logic          r_busy;
   logic [M-1:0]  w_gnt_oh;
   logic [IW-1:0] w_idx;
   logic          w_any;
   logic          w_update;
   logic          w_zero;
   logic [N-1:0]  w_dividend;
   logic [N-1:0]  w_divisor;
   assign w_update   = (r_state == S_IDLE) && w_any;
   assign w_dividend = req_dividend[int'(w_idx)*N +: N];
   assign w_divisor  = req_divisor[int'(w_idx)*N +: N];
`ifdef DIV_ARB_ZERO_CHECK_EN
   assign w_zero = (w_divisor == '0);
`else
   assign w_zero = 1'b0;
`endif
   rr_arbiter #(.M(M)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .i_req     (req),
      .i_update  (w_update),
      .o_gnt_oh  (w_gnt_oh),
      .o_gnt_idx (w_idx),
      .o_any     (w_any)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_gnt       <= '0;
         r_gnt_oh    <= '0;
         r_rsp_valid <= '0;
         r_rsp_q     <= '0;
         r_rsp_err   <= 1'b0;
         r_sen1      <= 1'b0;
         r_sen2      <= 1'b0;
         r_busy      <= 1'b0;
         r_dividend  <= '0;
         r_divisor   <= '0;
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            S_IDLE: if (w_any) begin
               r_gnt      <= w_idx;
               r_gnt_oh   <= w_gnt_oh;
               r_dividend <= w_dividend;
               r_divisor  <= w_divisor;
               r_busy     <= 1'b1;
               r_cnt      <= '0;
               if (w_zero) begin
                  r_rsp_q     <= '1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= w_gnt_oh;
                  r_state     <= S_RESP;
               end else begin
                  r_sen1  <= 1'b1;
                  r_state <= S_SEN1;
               end
            end
            S_SEN1: begin
               r_sen2  <= 1'b1;
               r_state <= S_BUSY;
            end
            // done takes priority over a simultaneous watchdog expiry
            S_BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               if (div_done || r_cnt == CW'(TIMEOUT)) begin
                  r_rsp_q     <= div_done ? div_q : '0;
                  r_rsp_err   <= !div_done;
                  r_rsp_valid <= r_gnt_oh;
                  r_sen1      <= 1'b0;
                  r_sen2      <= 1'b0;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: r_state <= S_GAP;
            S_GAP: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign rsp_valid    = r_rsp_valid;
   assign rsp_q        = r_rsp_q;
   assign rsp_err      = r_rsp_err;
   assign busy         = r_busy;
   assign gnt_idx      = r_gnt;
   assign div_dividend = r_dividend;
   assign div_divisor  = r_divisor;
   assign div_sen1     = r_sen1;
   assign div_sen2     = r_sen2;
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Sequencer and round-robin arbiter that shares one `div` instance among `M` requesters. It latches the granted requester's operands and drives the divider's two-step start handshake (`sen1`, then `sen2`). It then waits for `done`, returns the quotient to the winning requester, and guards against a hung divider with a watchdog. It sits between the control/measurement logic and the single divider datapath.

## Interface
- `N`, 20, operand and quotient width; must match the divider's `N`.
- `M`, 4, number of requesters (2..8).
- `TIMEOUT`, 64, maximum BUSY cycles to wait for `div_done` before aborting.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  M  per-requester request; held high until that requester's `rsp_valid` bit pulses.
- `req_dividend`  in  M*N  packed dividends; slice i is `[i*N +: N]`.
- `req_divisor`  in  M*N  packed divisors, same packing.
- `rsp_valid`  out  M  one-hot, one-cycle pulse to the serviced requester.
- `rsp_q`  out  N  quotient; valid while any `rsp_valid` bit is high.
- `rsp_err`  out  1  error flag, qualified by `rsp_valid` (timeout, or zero divisor when the zero check is enabled).
- `busy`  out  1  high in every state except IDLE.
- `gnt_idx`  out  clog2(M)  index of the current or last grant.
- `div_dividend`, `div_divisor`  out  N each  latched operands to the divider.
- `div_sen1`, `div_sen2`  out  1 each  divider start strobes.
- `div_q`  in  N  divider quotient.
- `div_done`  in  1  divider completion.

## Operation
- States and transitions:
  - IDLE → SEN1 → BUSY → RESP → GAP → IDLE.
  - BUSY → RESP also on timeout.
  - IDLE → RESP directly on a zero divisor, when the zero check is enabled.
- **IDLE:** if any `req` bit is high, the round-robin picker selects a winner. The controller registers `gnt_idx` and that requester's dividend and divisor into `div_dividend`/`div_divisor`, then moves to SEN1.
- **Round-robin order:**
  - Search starts at `last+1` modulo M.
  - After reset, index 0 has the highest priority.
  - With all requesters active, each requester is serviced at least once every M operations.
- **SEN1:** `div_sen1`=1, `div_sen2`=0.
- **BUSY:**
  - `div_sen1`=`div_sen2`=1; the watchdog counter increments every cycle.
  - `div_done` is sampled only in BUSY.
  - On `div_done`=1: capture `div_q` into `rsp_q`, set `rsp_err`=0, go to RESP.
  - On counter = TIMEOUT without `div_done`: set `rsp_q`=0, `rsp_err`=1, go to RESP.
  - If `div_done` and the timeout occur in the same cycle, `div_done` wins.
- **RESP:** `rsp_valid[gnt_idx]`=1 for exactly one cycle; both strobes are 0.
- **GAP:** one cycle with both strobes at 0, so the divider clears `done` and the requester drops `req`. Then return to IDLE.
- Operands stay stable on `div_*` from SEN1 through RESP.
- Requesters may change their operands only after their `rsp_valid` pulse.
- The watchdog counter is clog2(TIMEOUT+1) bits wide and clears on every entry to SEN1.
- `div_done` asserted outside BUSY is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `div_sen1`, `div_sen2`, `rsp_valid`, `rsp_err`, `busy` = 0.
  - `rsp_q`, `div_dividend`, `div_divisor`, `gnt_idx` = 0.
  - Round-robin pointer set so that index 0 is next.
- All outputs are registered, or decoded from registered state only; there are no combinational paths from inputs to outputs.
- Latency, with `req` sampled in IDLE at cycle t:
  - `div_sen1` rises at t+1.
  - `div_sen2` rises at t+2.
  - `div_done` seen at cycle d gives `rsp_valid` at d+1.
  - Next grant decision at d+3.
- Back-to-back overhead is 4 cycles per operation plus the divider latency.
- `reset` asserted mid-operation: at the next edge both strobes drop to 0 and state returns to IDLE. No `rsp_valid` is issued for the aborted operation.
- A `req` bit dropped while that requester is granted has no effect; the operation completes and its `rsp_valid` pulse is still issued.

## Configuration
- `DIV_ARB_ZERO_CHECK_EN` defined:
  - In IDLE, if the winner's divisor is 0, the divider is never started.
  - The next cycle is RESP with `rsp_q` = all ones and `rsp_err`=1.
  - The round-robin pointer advances as for a normal grant.
- Undefined: a zero divisor is issued to the divider like any other value. The result is whatever the divider returns, or a timeout.

## Structure
- Package `div_arb_pkg`:
  - State enum (IDLE, SEN1, BUSY, RESP, GAP).
  - State width constant.
  - Default `TIMEOUT` constant.
  - Helper function for the index width, clog2(M).
- Sub-module `rr_arbiter`: M-bit request vector in, pointer register plus one-hot and encoded grant out, pointer advanced on an `update` pulse. Instantiated once.

## Test plan
- Requester 0 requests 25/3 alone → `div_sen1` at t+1, `div_sen2` at t+2; `rsp_valid`=4'b0001, `rsp_q`=8, `rsp_err`=0.
- Requesters 0 and 2 request simultaneously (14400/7 and 14400/999) → requester 0 is serviced first (`rsp_q`=2057), then requester 2 (`rsp_q`=14); no overlap in strobes; GAP cycle present between operations.
- All four requesters held high for 8 operations → grant order 0,1,2,3,0,1,2,3.
- Divider model that never asserts `done` → `rsp_valid` exactly TIMEOUT+1 cycles after `div_sen2` rises, with `rsp_err`=1 and `rsp_q`=0.
- Divisor 0 with the macro defined → `rsp_q`=20'hFFFFF, `rsp_err`=1, `div_sen1` never asserted. Without the macro → strobes are issued normally.
- `reset` pulsed while in BUSY → strobes are 0 at the next edge, no `rsp_valid`, and the next grant goes to index 0.
